// File: rtl/counter_btn_ctrl_if.sv
// Pushbutton/switch inputs and counter control outputs of counter_btn_ctrl.
// master: the button front end; slave: the board side and the counter it drives.
interface counter_btn_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_load;
  logic [3:0] sw;
  logic       load;
  logic       up_down;
  logic       enable;
  logic [3:0] d_in;

  modport master (
    input  btn_up, btn_down, btn_load, sw,
    output load, up_down, enable, d_in
  );

  modport slave (
    output btn_up, btn_down, btn_load, sw,
    input  load, up_down, enable, d_in
  );
endinterface

// File: rtl/counter_btn_ctrl.sv
// Synchronises, debounces and edge-detects up/down/load buttons into counter control pulses.
// Define CNT_AUTO_REPEAT_EN to add hold-to-repeat on the up and down buttons.
module counter_btn_ctrl #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_btn_ctrl_if.master bus
);

  localparam int UP = 0;
  localparam int DN = 1;
  localparam int LD = 2;
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_sync_p0;
  logic [2:0] btn_sync_p1;
  logic [3:0] sw_sync_p0;
  logic [3:0] sw_sync_p1;
  logic [2:0] stable;
  logic [2:0] stable_p3;
  logic [2:0] press;

  logic       load_q;
  logic       enable_q;
  logic       up_down_q;
  logic [3:0] d_in_q;
  logic       load_nx;
  logic       enable_nx;
  logic       up_down_nx;
  logic [3:0] d_in_nx;

  assign btn_raw = {bus.btn_load, bus.btn_down, bus.btn_up};

  // p0/p1: two-flop synchronisers for every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
      sw_sync_p0  <= bus.sw;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  // p2: per-button debounce; stable flips only after DB_CYCLES consecutive disagreeing samples
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            st_p2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        st_p2 <= 1'b0;
      end else if (btn_sync_p1[i] == st_p2) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        st_p2 <= ~st_p2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign stable[i] = st_p2;
  end

  // p3: previous stable state, so a press is a rising edge of stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_p3 <= '0;
    else        stable_p3 <= stable;
  end

  assign press = stable & ~stable_p3;

`ifdef CNT_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [1:0] rpt_start;
  logic [1:0] rpt_fire;

  assign rpt_start[UP] = press[UP] & ~press[DN] & ~press[LD];
  assign rpt_start[DN] = press[DN] & ~press[UP] & ~press[LD];

  // cnt counts edges since the last pulse of this direction (real or repeat, fired or suppressed)
  for (genvar k = 0; k < 2; k++) begin : g_rpt
    logic [RPT_W-1:0] cnt;
    logic             active;
    logic             in_period;
    logic             hit;

    assign hit = active && (in_period ? (cnt == RPT_W'(REPEAT_PERIOD))
                                      : (cnt == RPT_W'(REPEAT_DELAY)));
    assign rpt_fire[k] = hit && stable[k] && !(stable[UP] && stable[DN]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt       <= '0;
        active    <= 1'b0;
        in_period <= 1'b0;
      end else if (!stable[k]) begin
        cnt       <= '0;
        active    <= 1'b0;
        in_period <= 1'b0;
      end else if (rpt_start[k]) begin
        cnt       <= RPT_W'(1);
        active    <= 1'b1;
        in_period <= 1'b0;
      end else if (hit) begin
        cnt       <= RPT_W'(1);
        in_period <= 1'b1;
      end else if (active) begin
        cnt <= cnt + RPT_W'(1);
      end
    end
  end
`endif

  // p4: arbitration into registered outputs; load wins, simultaneous up+down cancel
  always_comb begin
    load_nx    = 1'b0;
    enable_nx  = 1'b0;
    up_down_nx = up_down_q;
    d_in_nx    = d_in_q;
    if (press[LD]) begin
      load_nx = 1'b1;
      d_in_nx = sw_sync_p1;
    end else if (press[UP] && !press[DN]) begin
      enable_nx  = 1'b1;
      up_down_nx = 1'b1;
    end else if (press[DN] && !press[UP]) begin
      enable_nx  = 1'b1;
      up_down_nx = 1'b0;
    end
`ifdef CNT_AUTO_REPEAT_EN
    else if (rpt_fire[UP]) begin
      enable_nx  = 1'b1;
      up_down_nx = 1'b1;
    end else if (rpt_fire[DN]) begin
      enable_nx  = 1'b1;
      up_down_nx = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q    <= 1'b0;
      enable_q  <= 1'b0;
      up_down_q <= 1'b1;
      d_in_q    <= '0;
    end else begin
      load_q    <= load_nx;
      enable_q  <= enable_nx;
      up_down_q <= up_down_nx;
      d_in_q    <= d_in_nx;
    end
  end

  assign bus.load    = load_q;
  assign bus.enable  = enable_q;
  assign bus.up_down = up_down_q;
  assign bus.d_in    = d_in_q;

endmodule

// File: tb/tb_counter_btn_ctrl.sv
// Self-checking bench for counter_btn_ctrl: directed scenarios plus random button activity
// compared every cycle against a sample-history reference model.
module tb_counter_btn_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef CNT_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  counter_btn_ctrl_if bus();

  counter_btn_ctrl #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: raw sample history, debounced levels, pending presses, repeat anchors.
  logic [2:0] rq[$];
  logic [3:0] swq[$];
  logic [2:0] m_st;
  logic [2:0] m_press;
  int         anc[2];
  int         ecnt;
  logic       m_load;
  logic       m_en;
  logic       m_ud;
  logic [3:0] m_d;

  int n_en;
  int n_ld;
  int first_en;

  function automatic bit sched(int k);
    return (k == RD) || (k > RD && ((k - RD) % RP) == 0);
  endfunction

  task automatic model_reset();
    rq.delete();
    swq.delete();
    for (int i = 0; i < DB + 2; i++) begin
      rq.push_back(3'b000);
      swq.push_back(4'h0);
    end
    m_st    = '0;
    m_press = '0;
    anc[0]  = -1;
    anc[1]  = -1;
    ecnt    = 0;
    m_load  = 1'b0;
    m_en    = 1'b0;
    m_ud    = 1'b1;
    m_d     = 4'h0;
  endtask

  task automatic model_edge();
    bit         fire[2];
    bit         all_diff;
    logic [2:0] new_st;
    ecnt++;
    rq.push_back({bus.btn_load, bus.btn_down, bus.btn_up});
    swq.push_back(bus.sw);
    for (int k = 0; k < 2; k++) begin
      if (!m_st[k]) anc[k] = -1;
      fire[k] = RPT_EN && anc[k] >= 0 && m_st[k] && !(m_st[0] && m_st[1]) && sched(ecnt - anc[k]);
    end
    m_load = 1'b0;
    m_en   = 1'b0;
    if (m_press[2]) begin
      m_load = 1'b1;
      m_d    = swq[$-2];
    end else if (m_press[0] && !m_press[1]) begin
      m_en   = 1'b1;
      m_ud   = 1'b1;
      anc[0] = ecnt;
    end else if (m_press[1] && !m_press[0]) begin
      m_en   = 1'b1;
      m_ud   = 1'b0;
      anc[1] = ecnt;
    end else if (fire[0]) begin
      m_en = 1'b1;
      m_ud = 1'b1;
    end else if (fire[1]) begin
      m_en = 1'b1;
      m_ud = 1'b0;
    end
    // a level flips once the last DB synchronised samples all disagree with it
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (rq[$-j][b] == m_st[b]) all_diff = 1'b0;
      new_st[b] = all_diff ? ~m_st[b] : m_st[b];
    end
    m_press = new_st & ~m_st;
    m_st    = new_st;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic u, input logic d, input logic l, input logic [3:0] s);
    bus.btn_up   = u;
    bus.btn_down = d;
    bus.btn_load = l;
    bus.sw       = s;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk("load",    bus.load,    m_load);
    chk("enable",  bus.enable,  m_en);
    chk("up_down", bus.up_down, m_ud);
    chk("d_in",    bus.d_in,    m_d);
    chk("excl",    bus.load & bus.enable, 1'b0);
    if (bus.enable) begin
      n_en++;
      if (first_en < 0) first_en = ecnt;
    end
    if (bus.load) n_ld++;
  endtask

  task automatic clr_counts();
    n_en     = 0;
    n_ld     = 0;
    first_en = -1;
  endtask

  initial begin
    int   s;
    logic u, d, l;
    model_reset();
    clr_counts();

    // reset held with inputs toggling
    for (int i = 0; i < 6; i++) cyc(i[0], ~i[0], i[1], 4'(i * 3));
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'h0);

    // clean up press held 50 cycles
    clr_counts();
    cyc(1, 0, 0, 4'h0);
    s = ecnt;
    for (int i = 1; i < 50; i++) cyc(1, 0, 0, 4'h0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 4'h0);
    chk("up_first_edge", 4'(first_en - s), 4'(DB + 2));
    chk("up_pulses", 4'(n_en), RPT_EN ? 4'd7 : 4'd1);

    // bouncing down press, then held
    clr_counts();
    cyc(0, 1, 0, 4'h0); cyc(0, 0, 0, 4'h0); cyc(0, 1, 0, 4'h0);
    cyc(0, 1, 0, 4'h0); cyc(0, 0, 0, 4'h0);
    cyc(0, 1, 0, 4'h0);
    s = ecnt;
    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 4'h0);
    chk("down_first_edge", 4'(first_en - s), 4'(DB + 2));
    chk("down_pulses", 4'(n_en), 4'd1);
    chk("down_dir", bus.up_down, 1'b0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'h0);

    // 3-cycle glitch must not register
    clr_counts();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'h0);
    chk("glitch_pulses", 4'(n_en), 4'd0);

    // load captures sw and holds it
    clr_counts();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'b1010);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 4'b1010);
    chk("load_pulses", 4'(n_ld), 4'd1);
    chk("load_val", bus.d_in, 4'b1010);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'b0011);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'b0011);
    chk("load_hold", bus.d_in, 4'b1010);

    // load and up together: load only
    clr_counts();
    for (int i = 0; i < 12; i++) cyc(1, 0, 1, 4'b0110);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'b0110);
    chk("ldup_load", 4'(n_ld), 4'd1);
    chk("ldup_enable", 4'(n_en), 4'd0);
    chk("ldup_val", bus.d_in, 4'b0110);

    // up and down together: nothing, direction unchanged
    clr_counts();
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, 4'h0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'h0);
    chk("both_enable", 4'(n_en), 4'd0);
    chk("both_dir", bus.up_down, 1'b0);

    // reset in mid-operation with up held through release
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_ud", bus.up_down, 1'b1);
    chk("rst_async_d", bus.d_in, 4'h0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 4'h5);
    #3 rst_n = 1'b1;
    clr_counts();
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 4'h5);
    chk("rst_held_edge", 4'(first_en), 4'(DB + 3));
    chk("rst_held_pulses", 4'(n_en), 4'd1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'h0);

    // random button activity
    u = 0; d = 0; l = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) u = ~u;
      if ($urandom_range(0, 7) == 0) d = ~d;
      if ($urandom_range(0, 9) == 0) l = ~l;
      cyc(u, d, l, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
